// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// regfile_pkg : shared widths and types for the register-file write-back path
// Rev 1.0
// ============================================================================
package regfile_pkg;

    localparam int DATA_W   = 64;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 32;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } wb_req_t;

    typedef logic [NUM_REGS-1:0] busy_t;

    function automatic busy_t idx_onehot(input logic [ADDR_W-1:0] idx);
        return busy_t'(1) << idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter2.sv
`default_nettype none
// ============================================================================
// rr_arbiter2 : two-way round-robin arbiter; priority moves only on a conflict
// Rev 1.0
// ============================================================================
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_req,
    output logic [1:0] o_gnt
);

    // 1: requester 0 wins the next conflict
    logic r_prio0;

    always_comb begin
        o_gnt = i_req;
        if (i_req == 2'b11) begin
            o_gnt = r_prio0 ? 2'b01 : 2'b10;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prio0 <= 1'b1;
        end else if (i_req == 2'b11) begin
            r_prio0 <= ~r_prio0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/regfile_wb_scheduler.sv
`default_nettype none
// ============================================================================
// regfile_wb_scheduler : shares the register-file write port between ALU and
// load unit, and keeps a busy scoreboard that stalls decode on RAW/WAW hazards.
// Rev 1.0
// ============================================================================
module regfile_wb_scheduler
    import regfile_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              alu_valid,
    input  logic [ADDR_W-1:0] alu_rd,
    input  logic [DATA_W-1:0] alu_data,
    output logic              alu_ready,
    input  logic              mem_valid,
    input  logic [ADDR_W-1:0] mem_rd,
    input  logic [DATA_W-1:0] mem_data,
    output logic              mem_ready,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_rd,
    input  logic [ADDR_W-1:0] issue_rs1,
    input  logic [ADDR_W-1:0] issue_rs2,
    output logic              issue_stall,
    output logic              RegWrite,
    output logic [ADDR_W-1:0] WriteReg,
    output logic [DATA_W-1:0] WriteData,
    output logic [NUM_REGS-1:0] busy_vec
);

    logic [1:0] w_req;
    logic [1:0] w_gnt;
    wb_req_t    w_sel;
    wb_req_t    r_wb;
    busy_t      r_busy;
    busy_t      w_set;
    busy_t      w_clr;

    // x0 writes are absorbed here and never reach the arbiter
    assign w_req = {mem_valid && (mem_rd != '0), alu_valid && (alu_rd != '0)};

    rr_arbiter2 u_arb (
        .clk   (clock),
        .rst   (reset),
        .i_req (w_req),
        .o_gnt (w_gnt)
    );

    assign alu_ready = (alu_rd == '0) || w_gnt[0];
    assign mem_ready = (mem_rd == '0) || w_gnt[1];

    always_comb begin
        w_sel.valid = |w_gnt;
        w_sel.rd    = w_gnt[1] ? mem_rd   : alu_rd;
        w_sel.data  = w_gnt[1] ? mem_data : alu_data;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wb <= '0;
        end else begin
            r_wb.valid <= w_sel.valid;
            if (w_sel.valid) begin
                r_wb.rd   <= w_sel.rd;
                r_wb.data <= w_sel.data;
            end
        end
    end

    assign RegWrite  = r_wb.valid;
    assign WriteReg  = r_wb.rd;
    assign WriteData = r_wb.data;

    assign issue_stall = issue_valid &&
                         (((issue_rs1 != '0) && r_busy[issue_rs1]) ||
                          ((issue_rs2 != '0) && r_busy[issue_rs2]) ||
                          ((issue_rd  != '0) && r_busy[issue_rd]));

    assign w_clr = r_wb.valid ? idx_onehot(r_wb.rd) : '0;
    assign w_set = (issue_valid && !issue_stall && (issue_rd != '0)) ? idx_onehot(issue_rd) : '0;

    // set is applied after clear so a new owner survives a same-edge retire
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_busy <= '0;
        end else begin
            r_busy <= ((r_busy & ~w_clr) | w_set) & ~busy_t'(1);
        end
    end

    assign busy_vec = r_busy;

endmodule
`default_nettype wire
